// File: rtl/sum_uart_framer_pkg.sv
// Shared types and helpers for the sum framer: FSM states, line-ending bytes, hex/frame helpers.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package sum_uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // Uppercase ASCII for one hex nibble: '0'-'9' then 'A'-'F'.
  function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
    logic [7:0] ch;
    if (nib < 4'd10) ch = 8'h30 + {4'h0, nib};
    else             ch = 8'h37 + {4'h0, nib};
    return ch;
  endfunction

  // Bytes per frame: binary carries ceil(SW/8) bytes, ASCII carries ceil(SW/4) digits plus CR LF.
  function automatic int frame_len(input int width, input bit ascii_mode);
    int sw;
    sw = width + 1;
    if (ascii_mode) return (sw + 3) / 4 + 2;
    else            return (sw + 7) / 8;
  endfunction

endpackage

// File: rtl/sum_uart_framer_if.sv
// Operand/strobe inputs, byte stream to uart_tx and status outputs of the sum framer.
// Latency: none (wiring only).
// Backpressure: tx_valid/tx_ready byte handshake; the strobes are never stalled.
interface sum_uart_framer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] data_in;
  logic             load_a;
  logic             load_b;
  logic             send_req;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH:0]   sum;
  logic             busy;
  logic             frame_done;
  logic             overrun;

  modport master (
    output data_in, load_a, load_b, send_req, tx_ready,
    input  tx_data, tx_valid, sum, busy, frame_done, overrun
  );

  modport slave (
    input  data_in, load_a, load_b, send_req, tx_ready,
    output tx_data, tx_valid, sum, busy, frame_done, overrun
  );
endinterface

// File: rtl/sum_uart_framer_mux.sv
// Maps the frame snapshot and a byte index to the frame byte (binary LSB-first or ASCII hex + CR LF).
// Latency: combinational.
// Backpressure: none; the index is advanced by the framer FSM.
module sum_frame_mux #(
  parameter int WIDTH      = 4,
  parameter bit ASCII_MODE = 1'b0,
  parameter int IW         = 1
) (
  input  logic [WIDTH:0]  snap,
  input  logic [IW-1:0]   idx,
  output logic [7:0]      frame_byte
);
  import sum_uart_pkg::*;

  localparam int SW = WIDTH + 1;

  if (ASCII_MODE == 1'b0) begin : g_bin
    localparam int NB = (SW + 7) / 8;
    logic [NB*8-1:0] pad;
    assign pad = (NB*8)'(snap);

    // Byte i of the zero-extended snapshot, least significant byte first.
    always_comb begin
      frame_byte = 8'h00;
      for (int i = 0; i < NB; i++) begin
        if (idx == IW'(i)) frame_byte = pad[8*i +: 8];
      end
    end
  end else begin : g_asc
    localparam int ND = (SW + 3) / 4;
    logic [ND*4-1:0] pad;
    assign pad = (ND*4)'(snap);

    // Most significant digit first, then the CR LF terminator.
    always_comb begin
      frame_byte = 8'h00;
      for (int i = 0; i < ND; i++) begin
        if (idx == IW'(i)) frame_byte = hex2ascii(pad[4*(ND-1-i) +: 4]);
      end
      if (idx == IW'(ND))     frame_byte = CHAR_CR;
      if (idx == IW'(ND + 1)) frame_byte = CHAR_LF;
    end
  end

endmodule

// File: rtl/sum_uart_framer.sv
// Captures two operands, keeps their registered sum and sends one frame of it per request to uart_tx.
// Latency: sum one cycle after capture; first frame byte valid the cycle after the request edge.
// Backpressure: each byte held on tx_data until tx_ready; requests while busy are dropped and flag overrun.
module sum_uart_framer #(
  parameter int WIDTH      = 4,
  parameter bit ASCII_MODE = 1'b0,
  parameter bit AUTO_SEND  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  sum_uart_framer_if.slave bus
);
  import sum_uart_pkg::*;

  localparam int SW = WIDTH + 1;
  localparam int FL = frame_len(WIDTH, ASCII_MODE);
  localparam int IW = (FL > 1) ? $clog2(FL) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FL - 1);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [SW-1:0]    sum_q;
  logic [SW-1:0]    snap_q;
  logic [IW-1:0]    idx_q;
  logic             ovr_q;
  state_t           state_q;
  state_t           state_d;
  logic             eff_req;
  logic             accept;
  logic             last_byte;
  logic [7:0]       mux_byte;

  assign eff_req   = bus.send_req | (AUTO_SEND & bus.load_b);
  assign accept    = (state_q == SEND) & bus.tx_ready;
  assign last_byte = (idx_q == LAST_IDX);

  // Operand capture and the always-live registered sum; captures never touch the snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a  <= '0;
      op_b  <= '0;
      sum_q <= '0;
    end else begin
      if (bus.load_a) op_a <= bus.data_in;
      if (bus.load_b) op_b <= bus.data_in;
      sum_q <= SW'(op_a) + SW'(op_b);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: one frame per accepted request, one DONE cycle before the next can start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (eff_req) state_d = SEND;
      SEND:    if (accept && last_byte) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Snapshot on request (sum as it stands before this edge), byte index, sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q <= '0;
      idx_q  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && eff_req) begin
        snap_q <= sum_q;
        idx_q  <= '0;
      end else if (accept && !last_byte) begin
        idx_q <= idx_q + IW'(1);
      end
      if (eff_req && state_q != IDLE) ovr_q <= 1'b1;
    end
  end

  sum_frame_mux #(
    .WIDTH      (WIDTH),
    .ASCII_MODE (ASCII_MODE),
    .IW         (IW)
  ) u_mux (
    .snap       (snap_q),
    .idx        (idx_q),
    .frame_byte (mux_byte)
  );

  // FSM outputs; tx_data is forced to zero whenever no byte is offered.
  always_comb begin
    bus.tx_valid   = 1'b0;
    bus.tx_data    = 8'h00;
    bus.busy       = 1'b0;
    bus.frame_done = 1'b0;
    case (state_q)
      SEND: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = mux_byte;
        bus.busy     = 1'b1;
      end
      DONE: begin
        bus.busy       = 1'b1;
        bus.frame_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.sum     = sum_q;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_sum_uart_framer.sv
// Bench for sum_uart_framer: four configurations driven from one shared stimulus, checked against a frame-queue model.
// Latency: model outputs compared every cycle on the falling edge.
// Backpressure: tx_ready is driven by the bench (directed patterns, then random).
module tb_sum_uart_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] din;
  logic        load_a, load_b, send_req, tx_ready;

  always #5 clk = ~clk;

  // k=0: W4 binary, k=1: W4 ASCII, k=2: W12 binary, k=3: W4 binary with AUTO_SEND
  sum_uart_framer_if #(.WIDTH(4))  i0 ();
  sum_uart_framer_if #(.WIDTH(4))  i1 ();
  sum_uart_framer_if #(.WIDTH(12)) i2 ();
  sum_uart_framer_if #(.WIDTH(4))  i3 ();

  assign i0.data_in = din[3:0];
  assign i1.data_in = din[3:0];
  assign i2.data_in = din;
  assign i3.data_in = din[3:0];
  assign {i0.load_a, i1.load_a, i2.load_a, i3.load_a} = {4{load_a}};
  assign {i0.load_b, i1.load_b, i2.load_b, i3.load_b} = {4{load_b}};
  assign {i0.send_req, i1.send_req, i2.send_req, i3.send_req} = {4{send_req}};
  assign {i0.tx_ready, i1.tx_ready, i2.tx_ready, i3.tx_ready} = {4{tx_ready}};

  sum_uart_framer #(.WIDTH(4),  .ASCII_MODE(1'b0), .AUTO_SEND(1'b0)) u0 (.clk(clk), .reset(reset), .bus(i0));
  sum_uart_framer #(.WIDTH(4),  .ASCII_MODE(1'b1), .AUTO_SEND(1'b0)) u1 (.clk(clk), .reset(reset), .bus(i1));
  sum_uart_framer #(.WIDTH(12), .ASCII_MODE(1'b0), .AUTO_SEND(1'b0)) u2 (.clk(clk), .reset(reset), .bus(i2));
  sum_uart_framer #(.WIDTH(4),  .ASCII_MODE(1'b0), .AUTO_SEND(1'b1)) u3 (.clk(clk), .reset(reset), .bus(i3));

  logic [7:0]  o_data  [4];
  logic        o_valid [4];
  logic        o_busy  [4];
  logic        o_done  [4];
  logic        o_ovr   [4];
  logic [12:0] o_sum   [4];

  assign o_data[0] = i0.tx_data;  assign o_valid[0] = i0.tx_valid;  assign o_busy[0] = i0.busy;
  assign o_data[1] = i1.tx_data;  assign o_valid[1] = i1.tx_valid;  assign o_busy[1] = i1.busy;
  assign o_data[2] = i2.tx_data;  assign o_valid[2] = i2.tx_valid;  assign o_busy[2] = i2.busy;
  assign o_data[3] = i3.tx_data;  assign o_valid[3] = i3.tx_valid;  assign o_busy[3] = i3.busy;
  assign o_done[0] = i0.frame_done;  assign o_ovr[0] = i0.overrun;  assign o_sum[0] = 13'(i0.sum);
  assign o_done[1] = i1.frame_done;  assign o_ovr[1] = i1.overrun;  assign o_sum[1] = 13'(i1.sum);
  assign o_done[2] = i2.frame_done;  assign o_ovr[2] = i2.overrun;  assign o_sum[2] = 13'(i2.sum);
  assign o_done[3] = i3.frame_done;  assign o_ovr[3] = i3.overrun;  assign o_sum[3] = 13'(i3.sum);

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: operands, sum, the remaining bytes of the frame in flight, done pulse, overrun.
  int unsigned ma [4];
  int unsigned mb [4];
  int unsigned msum [4];
  logic [7:0]  mfr [4][8];
  int          mlen [4];
  int          mpos [4];
  bit          mdone [4];
  bit          movr [4];

  // Bytes the DUT actually handed over (valid && ready), per instance.
  logic [7:0] lg [4][64];
  int         lgn [4];

  function automatic int w_of(input int k);
    return (k == 2) ? 12 : 4;
  endfunction
  function automatic bit asc_of(input int k);
    return (k == 1);
  endfunction
  function automatic bit auto_of(input int k);
    return (k == 3);
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Expected frame of value v for instance k, from the frame rules.
  function automatic void load_frame(input int k, input int unsigned v);
    int sw, n, nib;
    sw = w_of(k) + 1;
    n  = 0;
    if (asc_of(k)) begin
      for (int i = (sw + 3) / 4 - 1; i >= 0; i--) begin
        nib = int'((v >> (4 * i)) & 15);
        mfr[k][n] = (nib < 10) ? 8'(48 + nib) : 8'(65 + nib - 10);
        n++;
      end
      mfr[k][n]   = 8'h0D;
      mfr[k][n+1] = 8'h0A;
      n += 2;
    end else begin
      for (int i = 0; i < (sw + 7) / 8; i++) begin
        mfr[k][n] = 8'((v >> (8 * i)) & 255);
        n++;
      end
    end
    mlen[k] = n;
    mpos[k] = 0;
  endfunction

  // Advance the model across the coming rising edge using the inputs now on the pins.
  function automatic void model_step();
    bit req, was_busy;
    int unsigned mask;
    for (int k = 0; k < 4; k++) begin
      if (reset) begin
        ma[k] = 0; mb[k] = 0; msum[k] = 0;
        mlen[k] = 0; mpos[k] = 0; mdone[k] = 0; movr[k] = 0;
      end else begin
        req      = send_req || (auto_of(k) && load_b);
        was_busy = (mpos[k] < mlen[k]) || mdone[k];
        mask     = (32'd1 << w_of(k)) - 1;
        if (mdone[k]) mdone[k] = 0;
        else if (mpos[k] < mlen[k] && tx_ready) begin
          mpos[k]++;
          if (mpos[k] == mlen[k]) mdone[k] = 1;
        end
        if (req) begin
          if (was_busy) movr[k] = 1;
          else          load_frame(k, msum[k]);
        end
        msum[k] = ma[k] + mb[k];
        if (load_a) ma[k] = din & mask;
        if (load_b) mb[k] = din & mask;
      end
    end
  endfunction

  // Per-cycle compare, log of accepted bytes, then model advance.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        chk("tx_valid", k, o_valid[k], (mpos[k] < mlen[k]));
        if (mpos[k] < mlen[k]) chk("tx_data", k, o_data[k], mfr[k][mpos[k]]);
        chk("busy", k, o_busy[k], (mpos[k] < mlen[k]) || mdone[k]);
        chk("frame_done", k, o_done[k], mdone[k]);
        chk("overrun", k, o_ovr[k], movr[k]);
        chk("sum", k, o_sum[k], msum[k]);
        if (o_valid[k] === 1'b1 && tx_ready && !reset && lgn[k] < 64) begin
          lg[k][lgn[k]] = o_data[k];
          lgn[k]++;
        end
      end
      model_step();
    end
  end

  // One cycle with the given inputs, sampled at the next rising edge.
  task automatic drive(input logic [11:0] d, input logic la, input logic lb, input logic sr,
                       input logic rdy, input logic rst = 1'b0);
    din = d; load_a = la; load_b = lb; send_req = sr; tx_ready = rdy; reset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(12'h000, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 4; k++) lgn[k] = 0;
  endtask

  // Compare the logged stream of instance k with n literal bytes (first byte in exp[7:0]).
  task automatic chk_frame(input string nm, input int k, input int n, input logic [31:0] exp);
    chk({nm, "_len"}, k, lgn[k], n);
    for (int i = 0; i < n; i++) chk(nm, k, lg[k][i], exp[8*i +: 8]);
  endtask

  initial begin
    din = '0; load_a = 0; load_b = 0; send_req = 0; tx_ready = 0; reset = 1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    drive(12'h000, 0, 0, 0, 0, 1'b1);
    chk("rst_sum", 0, o_sum[0], 0);
    chk("rst_busy", 1, o_busy[1], 0);
    chk("rst_valid", 2, o_valid[2], 0);
    chk("rst_data", 2, o_data[2], 0);

    // Binary W4: 9 + 8 = 17 -> single byte 0x11.
    clear_logs();
    drive(12'd9, 1, 0, 0, 1);
    drive(12'd8, 0, 1, 0, 1);
    idle(2, 1);
    chk("d1_sum", 0, o_sum[0], 17);
    drive(12'd0, 0, 0, 1, 1);
    chk("d1_first_valid", 0, o_valid[0], 1);
    chk("d1_first_byte", 0, o_data[0], 8'h11);
    drive(12'd0, 0, 0, 0, 1);
    chk("d1_done_pulse", 0, o_done[0], 1);
    idle(1, 1);
    chk("d1_done_gone", 0, o_done[0], 0);
    idle(8, 1);
    chk_frame("d1_bin", 0, 1, 32'h0000_0011);
    chk_frame("d1_asc", 1, 4, 32'h0A0D_3131);

    // ASCII W4 with both strobes together: 15 + 15 = 0x1E -> '1' 'E' CR LF.
    clear_logs();
    drive(12'd15, 1, 1, 0, 1);
    idle(2, 1);
    drive(12'd0, 0, 0, 1, 1);
    idle(10, 1);
    chk_frame("d2_asc", 1, 4, 32'h0A0D_4531);

    // W12 binary with tx_ready one cycle in three: 0xFFF + 1 -> 0x00 then 0x10.
    clear_logs();
    drive(12'hFFF, 1, 0, 0, 0);
    drive(12'h001, 0, 1, 0, 0);
    idle(2, 0);
    drive(12'd0, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) drive(12'd0, 0, 0, 0, (i % 3 == 2));
    idle(4, 1);
    chk_frame("d3_w12", 2, 2, 32'h0000_1000);

    // Request and load_a while a frame is in flight.
    chk("d4_ovr_before", 2, o_ovr[2], 0);
    clear_logs();
    drive(12'd0, 0, 0, 1, 0);
    drive(12'd0, 0, 0, 0, 0);
    drive(12'd3, 1, 0, 1, 0);
    chk("d4_ovr_set", 2, o_ovr[2], 1);
    idle(3, 0);
    idle(8, 1);
    chk_frame("d4_w12", 2, 2, 32'h0000_1000);
    chk("d4_ovr_sticky", 2, o_ovr[2], 1);
    chk("d4_sum", 2, o_sum[2], 4);

    // AUTO_SEND: A=2, B=1, then load_b of 5 sends the old sum 3; sum reads 7 a cycle later.
    clear_logs();
    drive(12'd2, 1, 0, 0, 1);
    drive(12'd1, 0, 1, 0, 1);
    idle(6, 1);
    drive(12'd5, 0, 1, 0, 1);
    chk("d5_sum_old", 3, o_sum[3], 3);
    idle(1, 1);
    chk("d5_sum_new", 3, o_sum[3], 7);
    idle(4, 1);
    chk("d5_last_byte", 3, (lgn[3] > 0) ? lg[3][lgn[3]-1] : 8'hFF, 8'h03);

    // Reset while the second ASCII byte is on offer, then a clean "00" CR LF frame.
    drive(12'd0, 0, 0, 1, 1);
    drive(12'd0, 0, 0, 0, 1);
    chk("d6_mid_valid", 1, o_valid[1], 1);
    drive(12'd0, 0, 0, 0, 0, 1'b1);
    chk("d6_rst_valid", 1, o_valid[1], 0);
    chk("d6_rst_busy", 1, o_busy[1], 0);
    chk("d6_rst_ovr", 2, o_ovr[2], 0);
    chk("d6_rst_sum", 1, o_sum[1], 0);
    idle(1, 1);
    clear_logs();
    drive(12'd0, 0, 0, 1, 1);
    idle(8, 1);
    chk_frame("d6_asc", 1, 4, 32'h0A0D_3030);

    // Random traffic, all checking done by the per-cycle compare.
    for (int i = 0; i < 3000; i++) begin
      drive(12'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 499) == 0));
    end
    idle(12, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
